// File: rtl/mic_frame_reader_pkg.sv
// Shared types and geometry helpers for the mic-array frame stream.
package mic_frame_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  localparam int DEF_ADDR_WIDTH     = 12;
  localparam int DEF_CHANNELS_WIDTH = 3;
  localparam int DEF_HALF_SIZE      = 1 << DEF_ADDR_WIDTH;
  localparam int DEF_SAMPLES_PER_CH =
    1 << (DEF_ADDR_WIDTH - DEF_CHANNELS_WIDTH);

  function automatic int half_size(input int aw);
    return 1 << aw;
  endfunction

  function automatic int samples_per_ch(input int aw, input int cw);
    return 1 << (aw - cw);
  endfunction

endpackage

// File: rtl/mic_skid_fifo.sv
// Two-entry valid/ready FIFO carrying {last, channel, data}.
module mic_skid_fifo
  import mic_frame_reader_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             pop;

  assign valid = (count != 2'd0);
  assign pop   = valid && ready;
  assign data  = mem[rd_ptr];

  // Flush beats a same-cycle push so stale returns never surface.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/mic_frame_reader.sv
// Reads each completed ping-pong half and streams it out
// tagged with channel and end-of-frame.
module mic_frame_reader
  import mic_frame_reader_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 12,
  parameter int CHANNELS        = 8,
  parameter int CHANNELS_WIDTH  = $clog2(CHANNELS),
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic                       buffer_selector,
  output logic                       read_en,
  output logic [ADDR_WIDTH-1:0]      addr_out,
  input  logic [DATA_WIDTH-1:0]      data_in,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic [CHANNELS_WIDTH-1:0]  m_channel,
  output logic                       m_last,
  output logic                       frame_done,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       overrun,
  input  logic                       overrun_clr
);

  localparam int FW = 1 + CHANNELS_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(half_size(ADDR_WIDTH) - 1);

  state_t                    state;
  state_t                    state_nx;
  logic                      sel_q;
  logic                      tog;
  logic                      over;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic                      inflight;
  logic                      tag_last;
  logic [CHANNELS_WIDTH-1:0] tag_ch;
  logic                      fifo_valid;
  logic [FW-1:0]             fifo_data;
  logic [1:0]                fifo_count;
  logic                      pop;
  logic [1:0]                slots;

  assign tog   = buffer_selector ^ sel_q;
  assign over  = tog && (state != IDLE);
  assign pop   = fifo_valid && m_ready;
  assign slots = fifo_count + {1'b0, inflight} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (tog && enable) state_nx = READ;
      READ:
        if (tog) state_nx = READ;
        else if (read_en && rd_addr == LAST_ADDR)
          state_nx = DRAIN;
      DRAIN:
        if (tog) state_nx = READ;
        else if (fifo_count == 2'd0 && !inflight)
          state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Reads are held off in the toggle cycle; that word would be discarded.
  always_comb begin
    read_en = 1'b0;
    if (state == READ && !tog && slots < 2'd2)
      read_en = 1'b1;
  end

  assign addr_out = rd_addr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_q       <= buffer_selector;
      rd_addr     <= '0;
      inflight    <= 1'b0;
      tag_last    <= 1'b0;
      tag_ch      <= '0;
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      sel_q    <= buffer_selector;
      inflight <= read_en;
      if (read_en) begin
        tag_last <= (rd_addr == LAST_ADDR);
        tag_ch   <= rd_addr[ADDR_WIDTH-1 -: CHANNELS_WIDTH];
      end
      if (tog)
        rd_addr <= '0;
      else if (read_en)
        rd_addr <= rd_addr + ADDR_WIDTH'(1);
      if (frame_done)
        frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
      if (over)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

  mic_skid_fifo #(
    .WIDTH (FW)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (over),
    .push      (inflight),
    .push_data ({tag_last, tag_ch, data_in}),
    .valid     (fifo_valid),
    .ready     (m_ready),
    .data      (fifo_data),
    .count     (fifo_count)
  );

  assign m_valid = fifo_valid;
  assign {m_last, m_channel, m_data} = fifo_data;
  assign frame_done = pop && m_last;

endmodule
